// File: rtl/gauss_pkg.sv
// Shared types and kernel constants for the streaming binomial blur.
package gauss_pkg;

   typedef enum logic [1:0] {
      MODE_BYPASS = 2'd0,
      MODE_G3     = 2'd1,
      MODE_G5     = 2'd2
   } mode_e;

   localparam int K_MAX   = 5;
   localparam int CROP    = 2;
   localparam int N_LINES = K_MAX - 1;

   localparam int W5 [K_MAX] = '{1, 4, 6, 4, 1};
   localparam int W3 [3]     = '{1, 2, 1};

   localparam int SH5  = 8;
   localparam int RND5 = 128;
   localparam int SH3  = 4;
   localparam int RND3 = 8;

   // The reserved encoding collapses onto bypass.
   function automatic mode_e decode_mode(input logic [1:0] m);
      case (m)
         2'd1:    return MODE_G3;
         2'd2:    return MODE_G5;
         default: return MODE_BYPASS;
      endcase
   endfunction

endpackage

// File: rtl/gauss_line_ram.sv
// One line of pixel history: simple dual-port RAM, registered read.
module gauss_line_ram
   import gauss_pkg::*;
#(
   parameter int DW    = 8,
   parameter int DEPTH = 172,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          i_we,
   input  logic [AW-1:0] i_waddr,
   input  logic [DW-1:0] i_wdata,
   input  logic          i_re,
   input  logic [AW-1:0] i_raddr,
   output logic [DW-1:0] o_rdata
);

   logic [DW-1:0] r_mem [DEPTH];
   logic [DW-1:0] r_rdata;

   // write and read share the edge; a same-address read returns the old word
   always_ff @(posedge clk) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
      if (i_re) r_rdata <= r_mem[i_raddr];
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/gauss_stream_filter.sv
// Streaming 5x5 / 3x3 binomial blur with crop, valid/ready on both sides.
// Line RAMs are read one pixel ahead (address of the next column) so the
// window can be registered on the very edge that accepts the pixel.
module gauss_stream_filter
   import gauss_pkg::*;
#(
   parameter int DW    = 8,
   parameter int IMG_W = 172,
   parameter int IMG_H = 106
) (
   input  logic          PixelClk,
   input  logic          Rst,
   input  logic [1:0]    mode,
   input  logic          s_valid,
   output logic          s_ready,
   input  logic [DW-1:0] s_data,
   input  logic          s_sof,
   output logic          m_valid,
   input  logic          m_ready,
   output logic [DW-1:0] m_data,
   output logic          m_sof,
   output logic          m_eol
);

   localparam int CW  = $clog2(IMG_W);
   localparam int RW  = $clog2(IMG_H);
   localparam int VW  = DW + 4;
   localparam int A5W = DW + 8;
   localparam int A3W = DW + 4;

   logic          w_en, w_hs, w_emit;
   logic [CW-1:0] r_col, w_col, w_col_nxt;
   logic [RW-1:0] r_row, w_row, w_row_nxt;
   logic          r_primed;
   mode_e         r_mode, w_mode;

   logic [DW-1:0] w_wr [N_LINES];
   logic [DW-1:0] w_rd [N_LINES];

   logic [DW-1:0] r_win [K_MAX][K_MAX];
   logic          r_v1, r_sof1, r_eol1;
   mode_e         r_mode1;

   logic [VW-1:0] w_vs [K_MAX];
   logic [VW-1:0] r_vs [K_MAX];
   logic          r_v2, r_sof2, r_eol2;
   mode_e         r_mode2;

   logic [A5W-1:0] w_acc5;
   logic [A3W-1:0] w_acc3;

   assign w_en      = !m_valid || m_ready;
   assign s_ready   = w_en;
   assign w_hs      = s_valid && w_en;
   assign w_col     = s_sof ? '0 : r_col;
   assign w_row     = s_sof ? '0 : r_row;
   assign w_col_nxt = (w_col == CW'(IMG_W - 1)) ? '0 : w_col + CW'(1);
   assign w_row_nxt = (w_col != CW'(IMG_W - 1) || w_row == RW'(IMG_H - 1)) ? w_row
                                                                          : w_row + RW'(1);
   assign w_mode    = s_sof ? decode_mode(mode) : r_mode;
   assign w_emit    = (s_sof || r_primed) && (w_row >= RW'(2 * CROP)) && (w_col >= CW'(2 * CROP));

   assign w_wr[0] = s_data;
   for (genvar k = 1; k < N_LINES; k++) begin : g_casc
      assign w_wr[k] = w_rd[k-1];
   end

   for (genvar k = 0; k < N_LINES; k++) begin : g_line
      gauss_line_ram #(.DW(DW), .DEPTH(IMG_W), .AW(CW)) u_line (
         .clk     (PixelClk),
         .i_we    (w_hs),
         .i_waddr (w_col),
         .i_wdata (w_wr[k]),
         .i_re    (w_hs),
         .i_raddr (w_col_nxt),
         .o_rdata (w_rd[k])
      );
   end

   // input geometry counters, frame priming and per-frame mode latch
   always_ff @(posedge PixelClk) begin
      if (Rst) begin
         r_col    <= '0;
         r_row    <= '0;
         r_primed <= 1'b0;
         r_mode   <= MODE_BYPASS;
      end else if (w_hs) begin
         r_col  <= w_col_nxt;
         r_row  <= w_row_nxt;
         r_mode <= w_mode;
         if (s_sof) r_primed <= 1'b1;
      end
   end

   // stage 1: shift the 5x5 window on each accepted pixel
   always_ff @(posedge PixelClk) begin
      if (Rst) begin
         for (int v = 0; v < K_MAX; v++)
            for (int h = 0; h < K_MAX; h++)
               r_win[v][h] <= '0;
         r_v1    <= 1'b0;
         r_sof1  <= 1'b0;
         r_eol1  <= 1'b0;
         r_mode1 <= MODE_BYPASS;
      end else if (w_en) begin
         r_v1 <= w_hs && w_emit;
         if (w_hs) begin
            for (int v = 0; v < K_MAX; v++)
               for (int h = 0; h < K_MAX - 1; h++)
                  r_win[v][h] <= r_win[v][h+1];
            r_win[0][K_MAX-1] <= w_rd[3];
            r_win[1][K_MAX-1] <= w_rd[2];
            r_win[2][K_MAX-1] <= w_rd[1];
            r_win[3][K_MAX-1] <= w_rd[0];
            r_win[4][K_MAX-1] <= s_data;
            r_sof1  <= (w_row == RW'(2 * CROP)) && (w_col == CW'(2 * CROP));
            r_eol1  <= (w_col == CW'(IMG_W - 1));
            r_mode1 <= w_mode;
         end
      end
   end

   // vertical pass: one weighted column sum per window column
   always_comb begin
      for (int h = 0; h < K_MAX; h++) begin
         w_vs[h] = '0;
         case (r_mode1)
            MODE_G5:
               for (int v = 0; v < K_MAX; v++)
                  w_vs[h] = w_vs[h] + VW'(W5[v]) * VW'(r_win[v][h]);
            MODE_G3:
               if (h >= 1 && h <= 3)
                  for (int v = 0; v < 3; v++)
                     w_vs[h] = w_vs[h] + VW'(W3[v]) * VW'(r_win[v+1][h]);
            default:
               if (h == CROP) w_vs[h] = VW'(r_win[CROP][CROP]);
         endcase
      end
   end

   // stage 2: register the column sums
   always_ff @(posedge PixelClk) begin
      if (Rst) begin
         for (int h = 0; h < K_MAX; h++) r_vs[h] <= '0;
         r_v2    <= 1'b0;
         r_sof2  <= 1'b0;
         r_eol2  <= 1'b0;
         r_mode2 <= MODE_BYPASS;
      end else if (w_en) begin
         for (int h = 0; h < K_MAX; h++) r_vs[h] <= w_vs[h];
         r_v2    <= r_v1;
         r_sof2  <= r_sof1;
         r_eol2  <= r_eol1;
         r_mode2 <= r_mode1;
      end
   end

   // horizontal pass with rounding offset folded into the accumulator seed
   always_comb begin
      w_acc5 = A5W'(RND5);
      w_acc3 = A3W'(RND3);
      for (int h = 0; h < K_MAX; h++)
         w_acc5 = w_acc5 + A5W'(W5[h]) * A5W'(r_vs[h]);
      for (int h = 0; h < 3; h++)
         w_acc3 = w_acc3 + A3W'(W3[h]) * A3W'(r_vs[h+1]);
   end

   // stage 3: normalise into the output register, holding while stalled
   always_ff @(posedge PixelClk) begin
      if (Rst) begin
         m_valid <= 1'b0;
         m_sof   <= 1'b0;
         m_eol   <= 1'b0;
         m_data  <= '0;
      end else if (w_en) begin
         m_valid <= r_v2;
         m_sof   <= r_v2 && r_sof2;
         m_eol   <= r_v2 && r_eol2;
         case (r_mode2)
            MODE_G5: m_data <= DW'(w_acc5 >> SH5);
            MODE_G3: m_data <= DW'(w_acc3 >> SH3);
            default: m_data <= r_vs[CROP][DW-1:0];
         endcase
      end
   end

endmodule

// File: tb/tb_gauss_stream_filter.sv
// Directed bench for gauss_stream_filter on a 16x8 frame.
module tb_gauss_stream_filter;

   localparam int DW = 8;
   localparam int IW = 16;
   localparam int IH = 8;
   localparam int OW = IW - 4;
   localparam int NOUT = (IW - 4) * (IH - 4);

   logic          PixelClk = 1'b0;
   logic          Rst = 1'b1;
   logic [1:0]    mode = 2'd0;
   logic          s_valid = 1'b0;
   logic          s_ready;
   logic [DW-1:0] s_data = '0;
   logic          s_sof = 1'b0;
   logic          m_valid;
   logic          m_ready = 1'b1;
   logic [DW-1:0] m_data;
   logic          m_sof;
   logic          m_eol;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int out_cnt = 0;
   logic [DW-1:0] out_data [1024];
   logic          out_sof  [1024];
   logic          out_eol  [1024];
   int            out_cyc  [1024];
   int            hs44 = 0;
   bit            bp_en = 1'b0;
   logic [3:0]    bp_pat = 4'b1001;
   bit            chk_ramp = 1'b0;
   int            ramp_base = 0;
   int            stall_bad = 0;
   int            stall_seen = 0;

   gauss_stream_filter #(.DW(DW), .IMG_W(IW), .IMG_H(IH)) dut (
      .PixelClk (PixelClk),
      .Rst      (Rst),
      .mode     (mode),
      .s_valid  (s_valid),
      .s_ready  (s_ready),
      .s_data   (s_data),
      .s_sof    (s_sof),
      .m_valid  (m_valid),
      .m_ready  (m_ready),
      .m_data   (m_data),
      .m_sof    (m_sof),
      .m_eol    (m_eol)
   );

   always #5 PixelClk = ~PixelClk;

   always @(posedge PixelClk) cyc <= cyc + 1;

   function automatic int ramp_exp(input int k);
      return (k % OW + 2) + 16 * (k / OW + 2);
   endfunction

   function automatic logic [DW-1:0] pix(input int kind, input int r, input int c);
      case (kind)
         0:       return 8'd100;
         1:       return (r == 4 && c == 8) ? 8'd255 : 8'd0;
         2:       return 8'(c + 16 * r);
         default: return 8'd0;
      endcase
   endfunction

   function automatic int got_data(input int i);
      return int'(out_data[i[9:0]]);
   endfunction

   function automatic int got_sof(input int i);
      return int'(out_sof[i[9:0]]);
   endfunction

   function automatic int got_eol(input int i);
      return int'(out_eol[i[9:0]]);
   endfunction

   // output monitor, sampled mid-cycle
   always @(negedge PixelClk) begin
      if (m_valid && m_ready) begin
         out_data[out_cnt[9:0]] <= m_data;
         out_sof[out_cnt[9:0]]  <= m_sof;
         out_eol[out_cnt[9:0]]  <= m_eol;
         out_cyc[out_cnt[9:0]]  <= cyc;
         out_cnt <= out_cnt + 1;
      end
      if (chk_ramp && m_valid) begin
         if (int'(m_data) != ramp_exp(out_cnt - ramp_base)) stall_bad <= stall_bad + 1;
         if (!m_ready) stall_seen <= stall_seen + 1;
      end
   end

   // downstream ready: 1-0-0-1 pattern when backpressure is enabled
   initial begin
      forever begin
         @(posedge PixelClk);
         #1;
         m_ready = bp_en ? bp_pat[cyc[1:0]] : 1'b1;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   task automatic check_val(input string tag, input int got, input int exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic send_px(input logic [DW-1:0] d, input logic sof, output int hs_at);
      int  n = 0;
      logic ok = 1'b0;
      hs_at = 0;
      s_valid = 1'b1;
      s_data  = d;
      s_sof   = sof;
      while (!ok && n < 100) begin
         @(negedge PixelClk);
         ok    = s_ready;
         hs_at = cyc;
         @(posedge PixelClk);
         #1;
         n++;
      end
      s_valid = 1'b0;
      s_sof   = 1'b0;
      if (!ok) check_val("hs_timeout", 0, 1);
   endtask

   task automatic send_range(input int kind, input logic sof_first, input int npx,
                             input int mode_at, input logic [1:0] new_mode);
      for (int k = 0; k < npx; k++) begin
         int r = k / IW;
         int c = k % IW;
         int t;
         if (k == mode_at) mode = new_mode;
         send_px(pix(kind, r, c), (k == 0) ? sof_first : 1'b0, t);
         if (r == 4 && c == 4) hs44 = t;
      end
   endtask

   task automatic wait_out(input int base, input int n);
      int k = 0;
      while (out_cnt - base < n && k < 400) begin
         @(posedge PixelClk);
         #1;
         k++;
      end
      repeat (10) @(posedge PixelClk);
      #1;
   endtask

   initial begin
      int base;
      int ss0;
      int sb0;
      int nsof;

      // reset defaults
      Rst = 1'b1;
      repeat (3) @(posedge PixelClk);
      #1;
      check_val("rst_m_valid", int'(m_valid), 0);
      check_val("rst_s_ready", int'(s_ready), 1);
      check_val("rst_m_data", int'(m_data), 0);
      check_val("rst_m_sof", int'(m_sof), 0);
      check_val("rst_m_eol", int'(m_eol), 0);
      Rst = 1'b0;

      // a whole frame without s_sof produces nothing
      base = out_cnt;
      mode = 2'd2;
      send_range(0, 1'b0, IW * IH, -1, 2'd0);
      wait_out(base, 1);
      check_val("pre_sof_out", out_cnt - base, 0);

      // flat frame, gauss5
      base = out_cnt;
      mode = 2'd2;
      send_range(0, 1'b1, IW * IH, -1, 2'd0);
      wait_out(base, NOUT);
      check_val("flat_count", out_cnt - base, NOUT);
      check_val("flat_latency", out_cyc[base[9:0]] - hs44, 3);
      for (int k = 0; k < NOUT; k++) begin
         check_val($sformatf("flat_d%0d", k), got_data(base + k), 100);
         check_val($sformatf("flat_sof%0d", k), got_sof(base + k), (k == 0) ? 1 : 0);
         check_val($sformatf("flat_eol%0d", k), got_eol(base + k), (k % OW == OW - 1) ? 1 : 0);
      end

      // impulse at (4,8), gauss5
      base = out_cnt;
      mode = 2'd2;
      send_range(1, 1'b1, IW * IH, -1, 2'd0);
      wait_out(base, NOUT);
      check_val("g5_count", out_cnt - base, NOUT);
      check_val("g5_c48", got_data(base + 30), 36);
      check_val("g5_c47", got_data(base + 29), 24);
      check_val("g5_c49", got_data(base + 31), 24);
      check_val("g5_c38", got_data(base + 18), 24);
      check_val("g5_c58", got_data(base + 42), 24);
      check_val("g5_c26", got_data(base + 4), 1);
      check_val("g5_c22", got_data(base + 0), 0);

      // impulse at (4,8), gauss3
      base = out_cnt;
      mode = 2'd1;
      send_range(1, 1'b1, IW * IH, -1, 2'd0);
      wait_out(base, NOUT);
      check_val("g3_count", out_cnt - base, NOUT);
      check_val("g3_c48", got_data(base + 30), 64);
      check_val("g3_c47", got_data(base + 29), 32);
      check_val("g3_c49", got_data(base + 31), 32);
      check_val("g3_c38", got_data(base + 18), 32);
      check_val("g3_c58", got_data(base + 42), 32);
      check_val("g3_c37", got_data(base + 17), 16);
      check_val("g3_c59", got_data(base + 43), 16);
      check_val("g3_c46", got_data(base + 28), 0);
      check_val("g3_c28", got_data(base + 6), 0);

      // ramp in bypass under 1-0-0-1 backpressure
      base = out_cnt;
      ramp_base = out_cnt;
      ss0 = stall_seen;
      sb0 = stall_bad;
      mode = 2'd0;
      chk_ramp = 1'b1;
      bp_en = 1'b1;
      send_range(2, 1'b1, IW * IH, -1, 2'd0);
      wait_out(base, NOUT);
      bp_en = 1'b0;
      chk_ramp = 1'b0;
      check_val("bp_count", out_cnt - base, NOUT);
      for (int k = 0; k < NOUT; k++)
         check_val($sformatf("bp_d%0d", k), got_data(base + k), ramp_exp(k));
      check_val("bp_hold", stall_bad - sb0, 0);
      check_val("bp_stalled", (stall_seen > ss0) ? 1 : 0, 1);

      // restart at (5,3): old bypass frame, then gauss5 impulse frame
      base = out_cnt;
      mode = 2'd0;
      send_range(2, 1'b1, 5 * IW + 3, 4 * IW, 2'd2);
      send_range(1, 1'b1, IW * IH, -1, 2'd0);
      wait_out(base, OW + NOUT);
      check_val("rs_count", out_cnt - base, OW + NOUT);
      for (int k = 0; k < OW; k++)
         check_val($sformatf("rs_old%0d", k), got_data(base + k), 32 + k + 2);
      check_val("rs_sof_old", got_sof(base), 1);
      nsof = 0;
      for (int k = 1; k < OW; k++) nsof += got_sof(base + k);
      check_val("rs_sof_between", nsof, 0);
      check_val("rs_sof_new", got_sof(base + OW), 1);
      check_val("rs_new_c22", got_data(base + OW), 0);
      check_val("rs_new_c48", got_data(base + OW + 30), 36);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
